gen_burst_ctrl: RTL and testbench
=================================

Name: gen_burst_ctrl

Overview:
Sequencing controller for the LUT-based function generator datapath. It drives the generator's configuration, address-clear and address-enable strobes, and paces sample writes into the downstream FIFO with a programmable rate divider and burst length. It honours FIFO-full backpressure. It sits between the system control interface and funct_generator, replacing ad-hoc strobing of enh_config/clrh_addr/enh_gen.

Parameters:
AMP_W, 8, width of amplitude configuration word
CNT_W, 16, width of burst-length and sample counters
DIV_W, 8, width of rate divider

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  start a burst; sampled only in IDLE
stop_i  in  1  abort current operation; returns to IDLE
sel_i  in  2  waveform select (0 sin, 1 cos, 2 triangle, 3 square)
amp_i  in  AMP_W  signed amplitude
burst_len_i  in  CNT_W  samples per burst; 0 = continuous until stop_i
rate_div_i  in  DIV_W  idle cycles between samples; 0 = one sample per cycle
fifo_full_i  in  1  downstream FIFO full
sel_o  out  2  latched waveform select to generator
amp_o  out  AMP_W  latched amplitude to generator
enh_config_o  out  1  generator config-load strobe
en_config_amp_o  out  1  generator amplitude-register load strobe
clrh_addr_o  out  1  generator LUT address clear
enh_gen_o  out  1  generator LUT address advance
wr_en_o  out  1  FIFO write strobe
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset: state=IDLE; sel_o=0, amp_o=0, all strobes 0, busy_o=0, done_o=0, counters and latched burst_len/rate_div=0. Reset mid-burst aborts immediately with no done_o.
- States: IDLE, CONFIG, CLEAR, GEN, DONE (registered state).
- IDLE: on start_i=1, latch sel_i, amp_i, burst_len_i and rate_div_i into sel_o/amp_o/internal registers; next state CONFIG. start_i in any other state is ignored. Input changes outside the IDLE start cycle have no effect.
- CONFIG (1 cycle): enh_config_o=1, en_config_amp_o=1 -> CLEAR.
- CLEAR (1 cycle): clrh_addr_o=1; sample counter=0, divider counter=0 -> GEN.
- GEN:
  - tick = (div_cnt==0).
  - wr_en_o = enh_gen_o = tick && !fifo_full_i (combinational from state, div_cnt and fifo_full_i; the two outputs are always identical).
  - On a write: sample_cnt += 1; div_cnt reloads rate_div.
  - Otherwise, if div_cnt>0, it decrements.
  - If tick && fifo_full_i: stall, div_cnt holds at 0, no address advance, and the write retries every cycle until full drops. No sample is dropped or duplicated.
  - If burst_len!=0 and the write makes sample_cnt==burst_len -> DONE.
  - If burst_len==0, GEN runs until stop_i; sample_cnt wraps at 2^CNT_W.
- DONE (1 cycle): done_o=1 -> IDLE.
- stop_i in CONFIG/CLEAR/GEN -> IDLE next cycle, no done_o. Strobes are suppressed in the stop cycle, and stop_i has priority over a pending write and over burst completion. stop_i in IDLE or DONE has no effect; DONE still pulses.
- Invariants:
  - clrh_addr_o and enh_gen_o are never high together.
  - enh_config_o is high only in CONFIG.
  - wr_en_o is never high while fifo_full_i=1.
- Latency: start_i at cycle 0 gives CONFIG in cycle 1, CLEAR in cycle 2, GEN from cycle 3. The first write lands in cycle 3 if not full. Sample spacing is rate_div+1 cycles. done_o fires the cycle after the last write.
- Arithmetic: counters are unsigned; amp passes through unchanged (signed, AMP_W bits).

Test Plan:
- Reset then start_i with sel=2, amp=8'sd50, burst_len=4, rate_div=0, full=0 -> config strobes cycle 1, clear cycle 2, wr_en_o cycles 3-6, done_o cycle 7, busy_o low cycle 8; sel_o=2, amp_o=50.
- burst_len=3, rate_div=2 -> writes in cycles 3, 6, 9; done_o cycle 10.
- burst_len=5, rate_div=0, fifo_full_i high cycles 4-6 -> writes in cycles 3, 7, 8, 9, 10; no wr_en_o during full; exactly 5 writes; done_o cycle 11.
- burst_len=0, rate_div=1, stop_i at cycle 20 -> writes every 2nd cycle from 3 to 19; no write in 20; IDLE in cycle 21; done_o never pulses.
- Second start_i at cycle 5 during burst_len=10, and sel_i changed to 1 -> ignored; sel_o stays 2; exactly 10 writes.
- rst asserted asynchronously mid-GEN (e.g. cycle 5) -> all outputs 0 immediately; no done_o. A subsequent start_i sequences normally from CONFIG.

Source files
------------

// File: rtl/gen_burst_ctrl.sv
// Burst sequencer for the LUT function generator: config/clear strobes, then
// rate-divided sample writes into the downstream FIFO with full backpressure.
module gen_burst_ctrl #(
  parameter int AMP_W = 8,
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       sel_i,
  input  logic [AMP_W-1:0] amp_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic [DIV_W-1:0] rate_div_i,
  input  logic             fifo_full_i,
  output logic [1:0]       sel_o,
  output logic [AMP_W-1:0] amp_o,
  output logic             enh_config_o,
  output logic             en_config_amp_o,
  output logic             clrh_addr_o,
  output logic             enh_gen_o,
  output logic             wr_en_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {IDLE, CONFIG, CLEAR, GEN, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [DIV_W-1:0] rate_div_q, rate_div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             write;

  // A write needs the divider expired, room downstream, and no abort this cycle.
  assign write = (state_q == GEN) && (div_cnt_q == '0) && !fifo_full_i && !stop_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      amp_q        <= '0;
      burst_len_q  <= '0;
      sample_cnt_q <= '0;
      rate_div_q   <= '0;
      div_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      amp_q        <= amp_d;
      burst_len_q  <= burst_len_d;
      sample_cnt_q <= sample_cnt_d;
      rate_div_q   <= rate_div_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    amp_d        = amp_q;
    burst_len_d  = burst_len_q;
    sample_cnt_d = sample_cnt_q;
    rate_div_d   = rate_div_q;
    div_cnt_d    = div_cnt_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        sel_d       = sel_i;
        amp_d       = amp_i;
        burst_len_d = burst_len_i;
        rate_div_d  = rate_div_i;
        state_d     = CONFIG;
      end
      CONFIG: state_d = stop_i ? IDLE : CLEAR;
      CLEAR: begin
        sample_cnt_d = '0;
        div_cnt_d    = '0;
        state_d      = stop_i ? IDLE : GEN;
      end
      GEN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (write) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          div_cnt_d    = rate_div_q;
          // burst_len of zero means run until stopped; the counter just wraps
          if (burst_len_q != '0 && sample_cnt_d == burst_len_q) state_d = DONE;
        end else if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_o           = sel_q;
    amp_o           = amp_q;
    enh_config_o    = (state_q == CONFIG) && !stop_i;
    en_config_amp_o = (state_q == CONFIG) && !stop_i;
    clrh_addr_o     = (state_q == CLEAR) && !stop_i;
    enh_gen_o       = write;
    wr_en_o         = write;
    busy_o          = (state_q != IDLE);
    done_o          = (state_q == DONE);
  end

endmodule

// File: tb/tb_gen_burst_ctrl.sv
// Directed bench for gen_burst_ctrl: a per-cycle vector table for the basic
// burst, then mask-driven sequences for divider, backpressure, stop and reset.
module tb_gen_burst_ctrl;
  logic       clk = 1'b0, rst;
  logic       start_i, stop_i, fifo_full_i;
  logic [1:0] sel_i;
  logic [7:0] amp_i, rate_div_i;
  logic [15:0] burst_len_i;
  logic [1:0] sel_o;
  logic [7:0] amp_o;
  logic       enh_config_o, en_config_amp_o, clrh_addr_o, enh_gen_o, wr_en_o, busy_o, done_o;

  int n_cmp = 0, n_bad = 0;

  gen_burst_ctrl #(.AMP_W(8), .CNT_W(16), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .sel_i(sel_i),
    .amp_i(amp_i), .burst_len_i(burst_len_i), .rate_div_i(rate_div_i),
    .fifo_full_i(fifo_full_i), .sel_o(sel_o), .amp_o(amp_o),
    .enh_config_o(enh_config_o), .en_config_amp_o(en_config_amp_o),
    .clrh_addr_o(clrh_addr_o), .enh_gen_o(enh_gen_o), .wr_en_o(wr_en_o),
    .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       cfg, clr, wr, busy, done;
    logic [1:0] sel;
    logic [7:0] amp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; stop_i = 0; fifo_full_i = 0;
    sel_i = 0; amp_i = 0; burst_len_i = 0; rate_div_i = 0;
  endtask

  // Cycle 0 carries start_i; after it every config input is scrambled to show
  // only the start-cycle values matter.
  task automatic run_burst(input string nm, input logic [1:0] sel, input logic [7:0] amp,
                           input logic [15:0] bl, input logic [7:0] rd,
                           input logic [31:0] start_m, input logic [31:0] full_m,
                           input logic [31:0] stop_m, input logic [31:0] wr_m,
                           input int done_c, input int idle_c, input int n);
    int nwr = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      start_i     = (c == 0) | start_m[c];
      sel_i       = (c == 0) ? sel : ~sel;
      amp_i       = (c == 0) ? amp : ~amp;
      burst_len_i = (c == 0) ? bl : bl + 16'd7;
      rate_div_i  = (c == 0) ? rd : rd + 8'd3;
      fifo_full_i = full_m[c];
      stop_i      = stop_m[c];
      @(negedge clk);
      if (wr_en_o) nwr++;
      chk({nm, "_wr"},   c, 32'(wr_en_o), 32'(wr_m[c]));
      chk({nm, "_gen"},  c, 32'(enh_gen_o), 32'(wr_m[c]));
      chk({nm, "_done"}, c, 32'(done_o), 32'(c == done_c));
      chk({nm, "_busy"}, c, 32'(busy_o), 32'(c >= 1 && c < idle_c));
      chk({nm, "_cfg"},  c, 32'(enh_config_o & en_config_amp_o), 32'(c == 1));
      chk({nm, "_clr"},  c, 32'(clrh_addr_o), 32'(c == 2));
      chk({nm, "_wr_vs_full"}, c, 32'(wr_en_o & fifo_full_i), 32'd0);
      if (c >= 1) begin
        chk({nm, "_sel"}, c, 32'(sel_o), 32'(sel));
        chk({nm, "_amp"}, c, 32'(amp_o), 32'(amp));
      end
    end
    chk({nm, "_nwrites"}, n, 32'(nwr), 32'($countones(wr_m)));
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #12;
    chk("reset_busy", 0, 32'(busy_o), 32'd0);
    chk("reset_sel",  0, 32'(sel_o), 32'd0);
    chk("reset_amp",  0, 32'(amp_o), 32'd0);
    chk("reset_strobes", 0, {27'd0, enh_config_o, clrh_addr_o, wr_en_o, enh_gen_o, done_o}, 32'd0);
    @(negedge clk); rst = 0;

    //             start cfg clr wr busy done sel amp
    tbl[0] = '{1'b1, 0, 0, 0, 0, 0, 2'd0, 8'd0};
    tbl[1] = '{1'b0, 1, 0, 0, 1, 0, 2'd2, 8'd50};
    tbl[2] = '{1'b0, 0, 1, 0, 1, 0, 2'd2, 8'd50};
    tbl[3] = '{1'b0, 0, 0, 1, 1, 0, 2'd2, 8'd50};
    tbl[4] = '{1'b0, 0, 0, 1, 1, 0, 2'd2, 8'd50};
    tbl[5] = '{1'b0, 0, 0, 1, 1, 0, 2'd2, 8'd50};
    tbl[6] = '{1'b0, 0, 0, 1, 1, 0, 2'd2, 8'd50};
    tbl[7] = '{1'b0, 0, 0, 0, 1, 1, 2'd2, 8'd50};
    tbl[8] = '{1'b0, 0, 0, 0, 0, 0, 2'd2, 8'd50};
    tbl[9] = '{1'b0, 0, 0, 0, 0, 0, 2'd2, 8'd50};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start_i = tbl[c].start; sel_i = 2'd2; amp_i = 8'd50;
      burst_len_i = 16'd4; rate_div_i = 8'd0; fifo_full_i = 0; stop_i = 0;
      @(negedge clk);
      chk("t1_cfg",  c, 32'(enh_config_o), 32'(tbl[c].cfg));
      chk("t1_cfga", c, 32'(en_config_amp_o), 32'(tbl[c].cfg));
      chk("t1_clr",  c, 32'(clrh_addr_o), 32'(tbl[c].clr));
      chk("t1_wr",   c, 32'(wr_en_o), 32'(tbl[c].wr));
      chk("t1_gen",  c, 32'(enh_gen_o), 32'(tbl[c].wr));
      chk("t1_busy", c, 32'(busy_o), 32'(tbl[c].busy));
      chk("t1_done", c, 32'(done_o), 32'(tbl[c].done));
      chk("t1_sel",  c, 32'(sel_o), 32'(tbl[c].sel));
      chk("t1_amp",  c, 32'(amp_o), 32'(tbl[c].amp));
    end
    idle_inputs();

    // rate_div=2: writes 3,6,9; done 10
    run_burst("div", 2'd1, 8'd9, 16'd3, 8'd2, 32'h0, 32'h0, 32'h0, 32'h248, 10, 11, 12);
    // full in 4-6: writes 3,7,8,9,10; done 11
    run_burst("full", 2'd3, 8'hC4, 16'd5, 8'd0, 32'h0, 32'h70, 32'h0, 32'h788, 11, 12, 13);
    // continuous rate_div=1, stop in 20: odd-cycle writes 3..19, idle at 21, no done
    run_burst("cont", 2'd0, 8'd1, 16'd0, 8'd1, 32'h0, 32'h0, 32'h100000, 32'hAAAA8, -1, 21, 23);
    // restart at cycle 5 ignored: writes 3..12, done 13
    run_burst("restart", 2'd2, 8'd77, 16'd10, 8'd0, 32'h20, 32'h0, 32'h0, 32'h1FF8, 13, 14, 16);

    // async reset mid-GEN
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start_i = (c == 0); sel_i = 2'd1; amp_i = 8'd33; burst_len_i = 16'd10; rate_div_i = 8'd0;
    end
    @(posedge clk); #1;
    start_i = 0;
    chk("pre_rst_wr", 5, 32'(wr_en_o), 32'd1);
    #2 rst = 1;
    #1;
    chk("rst_busy", 5, 32'(busy_o), 32'd0);
    chk("rst_sel",  5, 32'(sel_o), 32'd0);
    chk("rst_amp",  5, 32'(amp_o), 32'd0);
    chk("rst_strobes", 5, {27'd0, enh_config_o, clrh_addr_o, wr_en_o, enh_gen_o, done_o}, 32'd0);
    @(negedge clk); rst = 0;
    chk("rst_no_done", 6, 32'(done_o), 32'd0);
    run_burst("post_rst", 2'd3, 8'hF9, 16'd2, 8'd0, 32'h0, 32'h0, 32'h0, 32'h18, 5, 6, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
